// File: rtl/lmk_spi_resp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lmk_spi_pkg: shared FSM states, frame geometry and helpers for lmk_spi_resp.
// Rev 1.0
// ---------------------------------------------------------------------------
package lmk_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_TAIL  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam int   FRAME_W      = 24;
  localparam int   HDR_W        = 16;
  localparam int   DATA_W       = 8;
  localparam int   ADDR_FIELD_W = 15;
  localparam logic RW_READ      = 1'b1;

  // True when no address bit above the implemented width is set.
  function automatic logic addr_in_range(input logic [ADDR_FIELD_W-1:0] addr,
                                         input int unsigned           aw);
    return (addr >> aw) == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lmk_spi_resp_in_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_in_sync: 2-flop synchronizers for SCSN/SCL/SDIO plus SCL and SCSN edge detect.
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_in_sync (
  input  logic I_Clk,
  input  logic I_Rst_n,
  input  logic I_Scsn,
  input  logic I_Scl,
  input  logic I_Sdio_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic sdio_s
);

  // Bits [1:0] are the synchronizer, bit [2] is the edge-detect history.
  logic [2:0] cs_q, cs_d;
  logic [2:0] scl_q, scl_d;
  logic [1:0] sdio_q, sdio_d;

  always_comb begin
    cs_d   = {cs_q[1:0], I_Scsn};
    scl_d  = {scl_q[1:0], I_Scl};
    sdio_d = {sdio_q[0], I_Sdio_in};
  end

  always_ff @(posedge I_Clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      cs_q   <= 3'b111;
      scl_q  <= 3'b000;
      sdio_q <= 2'b00;
    end else begin
      cs_q   <= cs_d;
      scl_q  <= scl_d;
      sdio_q <= sdio_d;
    end
  end

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign sdio_s   = sdio_q[1];

endmodule
`default_nettype wire

// File: rtl/lmk_spi_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lmk_spi_resp: 3-wire SPI responder decoding 24-bit LMK frames into a byte bank.
// Optional SDIO read drive: LMK_SPI_RESP_READBACK_EN. Rev 1.0
// ---------------------------------------------------------------------------
module lmk_spi_resp
  import lmk_spi_pkg::*;
#(
  parameter int         ADDR_W  = 9,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic              I_Clk,
  input  logic              I_Rst_n,
  input  logic              I_Scsn,
  input  logic              I_Scl,
  input  logic              I_Sdio_in,
  output logic              O_Sdio_out,
  output logic              O_Sdio_oe,
  output logic              O_Wr_Valid,
  output logic [ADDR_W-1:0] O_Wr_Addr,
  output logic [7:0]        O_Wr_Data,
  input  logic [ADDR_W-1:0] I_Rd_Addr,
  output logic [7:0]        O_Rd_Data,
  output logic              O_Frame_Err,
  output logic              O_Addr_Err,
  output logic [15:0]       O_Frame_Cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic scl_rise, scl_fall, cs_fall, cs_rise, sdio_s;

  spi_in_sync u_sync (
    .I_Clk     (I_Clk),
    .I_Rst_n   (I_Rst_n),
    .I_Scsn    (I_Scsn),
    .I_Scl     (I_Scl),
    .I_Sdio_in (I_Sdio_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .sdio_s    (sdio_s)
  );

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                commit_q, commit_d;
  logic                stg_q, stg_d, stg_wr_q, stg_wr_d, stg_ok_q, stg_ok_d;
  logic [ADDR_W-1:0]   stg_addr_q, stg_addr_d, wr_addr_q, wr_addr_d;
  logic [7:0]          stg_data_q, stg_data_d, wr_data_q, wr_data_d;
  logic                wr_valid_q, wr_valid_d, addr_err_q, addr_err_d;
  logic                frame_err_q, frame_err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [7:0]          bank_q [DEPTH];
  logic [7:0]          rd_data_q;

`ifdef LMK_SPI_RESP_READBACK_EN
  localparam state_e RD_STATE = ST_RDATA;
`else
  // Without readback a read frame simply clocks through its data bits.
  localparam state_e RD_STATE = ST_WDATA;
  logic unused_scl_fall;
  assign unused_scl_fall = scl_fall;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    data_d      = data_q;
    commit_d    = 1'b0;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_HDR;
          cnt_d   = '0;
        end
      end
      ST_HDR: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (scl_rise) begin
          hdr_d = {hdr_q[HDR_W-2:0], sdio_s};
          cnt_d = cnt_q + 5'd1;
          // R/W bit sits at HDR_W-2 just before the final header shift.
          if (cnt_q == 5'(HDR_W - 1))
            state_d = (hdr_q[HDR_W-2] == RW_READ) ? RD_STATE : ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (scl_rise) begin
          data_d = {data_q[DATA_W-2:0], sdio_s};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'(FRAME_W - 1)) begin
            state_d  = ST_TAIL;
            commit_d = 1'b1;
          end
        end
      end
`ifdef LMK_SPI_RESP_READBACK_EN
      ST_RDATA: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (scl_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(FRAME_W - 1)) begin
            state_d  = ST_TAIL;
            commit_d = 1'b1;
          end
        end
      end
`endif
      ST_TAIL: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (scl_rise) begin
          state_d     = ST_ERR;
          frame_err_d = 1'b1;
        end
      end
      ST_ERR: begin
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Two-stage commit pipeline: latch the decoded frame, then strobe and write.
  always_comb begin
    stg_d      = commit_q;
    stg_wr_d   = (hdr_q[HDR_W-1] != RW_READ);
    stg_ok_d   = addr_in_range(hdr_q[ADDR_FIELD_W-1:0], ADDR_W);
    stg_addr_d = hdr_q[ADDR_W-1:0];
    stg_data_d = data_q;
    wr_valid_d = stg_q && stg_wr_q && stg_ok_q;
    addr_err_d = stg_q && !stg_ok_q;
    wr_addr_d  = wr_valid_d ? stg_addr_q : wr_addr_q;
    wr_data_d  = wr_valid_d ? stg_data_q : wr_data_q;
  end

  always_ff @(posedge I_Clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hdr_q       <= '0;
      data_q      <= '0;
      commit_q    <= 1'b0;
      stg_q       <= 1'b0;
      stg_wr_q    <= 1'b0;
      stg_ok_q    <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
      wr_valid_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      data_q      <= data_d;
      commit_q    <= commit_d;
      stg_q       <= stg_d;
      stg_wr_q    <= stg_wr_d;
      stg_ok_q    <= stg_ok_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
      wr_valid_q  <= wr_valid_d;
      addr_err_q  <= addr_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef LMK_SPI_RESP_READBACK_EN
  logic       sdio_out_q, sdio_out_d, sdio_oe_q, sdio_oe_d;
  logic [7:0] spi_rd_q, rd_byte;
  logic       oe_drop;

  assign rd_byte = addr_in_range(hdr_q[ADDR_FIELD_W-1:0], ADDR_W) ? spi_rd_q : 8'h00;
  assign oe_drop = (state_d != state_q) && (state_d == ST_IDLE || state_d == ST_ERR);

  // cnt_q is 16..23 on the falls of the data phase; its low bits pick MSB first.
  always_comb begin
    sdio_out_d = sdio_out_q;
    sdio_oe_d  = sdio_oe_q;
    if (oe_drop) begin
      sdio_out_d = 1'b0;
      sdio_oe_d  = 1'b0;
    end else if (state_q == ST_RDATA && scl_fall) begin
      sdio_out_d = rd_byte[~cnt_q[2:0]];
      sdio_oe_d  = 1'b1;
    end
  end

  always_ff @(posedge I_Clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      sdio_out_q <= 1'b0;
      sdio_oe_q  <= 1'b0;
    end else begin
      sdio_out_q <= sdio_out_d;
      sdio_oe_q  <= sdio_oe_d;
    end
  end

  assign O_Sdio_out = sdio_out_q;
  assign O_Sdio_oe  = sdio_oe_q;
`else
  assign O_Sdio_out = 1'b0;
  assign O_Sdio_oe  = 1'b0;
`endif

  // Fabric read uses the pre-write contents when it collides with an SPI write.
  always_ff @(posedge I_Clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= RST_VAL;
      rd_data_q <= 8'h00;
`ifdef LMK_SPI_RESP_READBACK_EN
      spi_rd_q  <= 8'h00;
`endif
    end else begin
      if (wr_valid_d) bank_q[stg_addr_q] <= stg_data_q;
      rd_data_q <= bank_q[I_Rd_Addr];
`ifdef LMK_SPI_RESP_READBACK_EN
      spi_rd_q  <= bank_q[hdr_q[ADDR_W-1:0]];
`endif
    end
  end

  assign O_Wr_Valid  = wr_valid_q;
  assign O_Wr_Addr   = wr_addr_q;
  assign O_Wr_Data   = wr_data_q;
  assign O_Rd_Data   = rd_data_q;
  assign O_Frame_Err = frame_err_q;
  assign O_Addr_Err  = addr_err_q;
  assign O_Frame_Cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: doc/lmk_spi_resp.md
Name: lmk_spi_resp

Overview:
- 3-wire SPI responder (slave) for the LMK-style 24-bit frame produced by the team's LMK04610 configuration master.
- Decodes R/W + address + data frames into a local register bank; write strobes go out to fabric.
- Drives read data back on the shared SDIO line.
- Used as an in-fabric device model for bring-up, and as a config port so an external master can program FPGA-side clock registers.

Parameters:
- ADDR_W, 9, implemented register address bits; bank depth is 2^ADDR_W bytes, covering 0x000..0x1FF.
- RST_VAL, 8'h00, reset value of every bank byte.

Ports:
- I_Clk  in  1  system clock; must be ≥4x the SCL frequency, with each SCL phase ≥2 I_Clk cycles.
- I_Rst_n  in  1  asynchronous, active-low reset.
- I_Scsn  in  1  chip select, active low, asynchronous to I_Clk.
- I_Scl  in  1  serial clock, asynchronous.
- I_Sdio_in  in  1  SDIO pad input.
- O_Sdio_out  out  1  SDIO pad output data.
- O_Sdio_oe  out  1  SDIO pad output enable, 1 = drive.
- O_Wr_Valid  out  1  one-cycle write strobe.
- O_Wr_Addr  out  ADDR_W  write address, valid with O_Wr_Valid.
- O_Wr_Data  out  8  write data, valid with O_Wr_Valid.
- I_Rd_Addr  in  ADDR_W  fabric-side bank read address.
- O_Rd_Data  out  8  bank byte at I_Rd_Addr, registered, 1-cycle latency.
- O_Frame_Err  out  1  one-cycle pulse on an aborted or over-length frame.
- O_Addr_Err  out  1  one-cycle pulse when the address is out of range.
- O_Frame_Cnt  out  16  count of completed frames, wraps 0xFFFF→0.

Behaviour:
- Reset: every output is 0; the bank is set to RST_VAL; FSM goes to ST_IDLE; synchronizers load Scsn=1, Scl=0.
- Input sync: I_Scsn, I_Scl and I_Sdio_in each pass through a 2-flop synchronizer. One further register provides SCL rise/fall and SCSN fall/rise detection.
- Sampling: SDIO is sampled on the synchronized SCL rise, MSB first.
- Frame layout (24 bits):
  - bit23 = R/W, 1 = read.
  - bits22:8 = address.
  - bits7:0 = data.
- Bit counter: 5 bits, cleared on SCSN fall.
- FSM:
  - ST_IDLE: SCSN fall → ST_HDR.
  - ST_HDR: shift 16 bits. After the 16th rise, go to ST_WDATA if R/W=0, otherwise ST_RDATA.
  - ST_WDATA: shift 8 bits. On the 24th rise, commit and go to ST_TAIL.
  - ST_RDATA: on each SCL fall, drive the next bank bit MSB first, starting at the fall after the 16th rise. Count 8 rises, then go to ST_TAIL.
  - ST_TAIL: SCSN rise → ST_IDLE and increment O_Frame_Cnt. Any SCL rise in this state → ST_ERR.
  - ST_ERR: pulse O_Frame_Err once on entry, wait for SCSN rise → ST_IDLE. O_Frame_Cnt is not incremented.
- Abort: SCSN rise while in ST_HDR, ST_WDATA or ST_RDATA pulses O_Frame_Err, discards the partial frame (no write) and returns to ST_IDLE.
- Address check: if address bits 14:ADDR_W are nonzero, the write is suppressed and O_Addr_Err pulses at commit. A read with such an address returns 0x00 and also pulses O_Addr_Err.
- Write latency: O_Wr_Valid is high on the 4th I_Clk rising edge after the I_Clk edge that first sees I_Scl high (24th bit). The bank is updated on the same edge.
- Simultaneous events: a fabric I_Rd_Addr read colliding with a same-cycle SPI write returns the old data.
- O_Sdio_oe:
  - asserts on the same edge that drives the first read bit;
  - deasserts on SCSN rise, on entry to ST_ERR, and in reset.
  - It is never 1 in ST_IDLE or ST_HDR.
- Back-to-back frames: SCSN may rise and fall with only 2 I_Clk of high time between frames; no frame is lost.
- Asynchronous reset mid-frame: all state clears immediately. The next SCSN fall starts a fresh frame; a frame already in progress during reset is not recovered.

Optional Feature:
- Macro LMK_SPI_RESP_READBACK_EN.
- Defined: read frames drive SDIO as described above.
- Undefined:
  - O_Sdio_oe and O_Sdio_out are tied 0 and ST_RDATA logic is removed.
  - A read frame shifts its 8 data clocks with no drive, then completes normally and increments O_Frame_Cnt.
  - The address check still applies and can pulse O_Addr_Err.

Decomposition:
- Package lmk_spi_pkg holds:
  - FSM state enum (ST_IDLE, ST_HDR, ST_WDATA, ST_RDATA, ST_TAIL, ST_ERR);
  - FRAME_W=24, HDR_W=16, DATA_W=8, ADDR_FIELD_W=15;
  - RW_READ=1'b1.
- Sub-module spi_in_sync: 3-signal 2-flop synchronizer plus edge detector, outputs scl_rise, scl_fall, cs_fall, cs_rise, sdio_s.
- Register bank: inferred RAM in the top level.

Test Plan:
- Write frame 0x000346 at SCL = I_Clk/8 → O_Wr_Valid one cycle with O_Wr_Addr=0x003, O_Wr_Data=0x46. Then I_Rd_Addr=3 gives O_Rd_Data=0x46; O_Frame_Cnt=1.
- After that write, read frame 0x800300 (macro defined) → during the data phase SDIO drives 0,1,0,0,0,1,1,0; O_Sdio_oe high from the fall after bit 16 until SCSN rise; no O_Wr_Valid.
- SCSN rise after 12 bits of 0x001101 → O_Frame_Err pulse, no write, reg 0x011 unchanged, O_Frame_Cnt unchanged.
- Frame 0x7FFF55 (address 0x7FFF with ADDR_W=9) → O_Addr_Err pulse, no O_Wr_Valid, bank unchanged.
- 25 SCL clocks in one CS window carrying 0x012408 → the write to 0x124=0x08 commits, then O_Frame_Err pulses on the 25th rise; O_Frame_Cnt is not incremented.
- Assert I_Rst_n low mid ST_RDATA → O_Sdio_oe=0 immediately, bank = RST_VAL. The following frame 0x000A5A writes 0x5A to 0x00A correctly.
